// File: rtl/tsn_sched_pkg.sv
// Shared definitions for the TSN slot scheduler: sizes, FSM states,
// config-table entry layout and small combinational helpers.
package tsn_sched_pkg;

  localparam int FLOW_NUM = 8;
  localparam int SLOT_W   = 9;
  localparam int CNT_W    = 32;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ISSUE,
    WAIT_DONE
  } sched_state_t;

  typedef struct packed {
    logic              en;
    logic [SLOT_W-1:0] slot;
  } flow_cfg_t;

  // Number of set bits in a flow vector (0..8).
  function automatic logic [3:0] popcount_flows(input logic [FLOW_NUM-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < FLOW_NUM; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Index of the set bit of a one-hot flow vector.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [FLOW_NUM-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < FLOW_NUM; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tsn_sched_arb.sv
// Flow arbiter: picks one pending flow and returns it one-hot.
// Build option TSS_RR_ARB_EN selects round-robin (search starts after the
// last granted index); otherwise the lowest pending index wins.
module tsn_sched_arb
  import tsn_sched_pkg::*;
(
  input  logic [FLOW_NUM-1:0] pending,
`ifdef TSS_RR_ARB_EN
  input  logic [IDX_W-1:0]    last_idx,
`endif
  output logic [FLOW_NUM-1:0] grant
);

`ifdef TSS_RR_ARB_EN
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;

  // Circular search from last_idx+1; the 3-bit index wraps modulo 8.
  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= FLOW_NUM; k++) begin
      rr_idx = last_idx + IDX_W'(k);
      if (!rr_found && pending[rr_idx]) begin
        grant[rr_idx] = 1'b1;
        rr_found      = 1'b1;
      end
    end
  end
`else
  logic fp_found;

  // Fixed priority: first set bit from index 0 upward.
  always_comb begin
    grant    = '0;
    fp_found = 1'b0;
    for (int i = 0; i < FLOW_NUM; i++) begin
      if (!fp_found && pending[i]) begin
        grant[i] = 1'b1;
        fp_found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/tsn_slot_scheduler.sv
// TSN time-slot scheduler: on each new slot from the LCM, marks the flows
// configured for that slot as pending and issues them one at a time to the
// header extender, waiting for pkt_done (or a timeout) between grants.
// Flows left unsent, and abandoned grants, are counted in out_miss_cnt.
// Build option TSS_RR_ARB_EN enables round-robin arbitration.
module tsn_slot_scheduler
  import tsn_sched_pkg::*;
#(
  parameter string PLATFORM     = "xilinx",
  parameter int    DONE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_start,
  input  logic [SLOT_W-1:0] slot_ID,
  input  logic              cfg_wr,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic              cfg_en,
  input  logic              pkt_done,
  output logic [7:0]        out_selected,
  output logic              out_hdr_req,
  output logic              out_busy,
  output logic [31:0]       out_miss_cnt
);

  // The timeout fires in the DONE_TIMEOUT-th cycle spent in WAIT_DONE.
  localparam logic [7:0] TIMEOUT_LAST = 8'(DONE_TIMEOUT - 1);

  // The vendor tag is informational only and never changes behaviour.
  if (PLATFORM == "") begin : g_platform_untagged
  end

  flow_cfg_t           cfg_tbl [FLOW_NUM];
  logic [SLOT_W-1:0]   slot_hist;
  logic                hist_valid;
  logic                slot_tick;
  logic [FLOW_NUM-1:0] slot_match;
  logic [FLOW_NUM-1:0] pending;
  logic [FLOW_NUM-1:0] arb_grant;
  logic [FLOW_NUM-1:0] grant;
  logic [7:0]          to_cnt;
  logic                timeout;
  logic [CNT_W-1:0]    miss_cnt;
  logic [CNT_W:0]      miss_sum;
  logic [3:0]          miss_inc;
  sched_state_t        state;
  sched_state_t        state_nxt;

`ifdef TSS_RR_ARB_EN
  logic [IDX_W-1:0]    last_idx;

  // Remember the last granted index; 7 after reset so flow 0 is tried first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx <= IDX_W'(FLOW_NUM - 1);
    end else if (state == ARB && arb_grant != '0) begin
      last_idx <= onehot_to_idx(arb_grant);
    end
  end

  tsn_sched_arb u_arb (
    .pending  (pending),
    .last_idx (last_idx),
    .grant    (arb_grant)
  );
`else
  tsn_sched_arb u_arb (
    .pending (pending),
    .grant   (arb_grant)
  );
`endif

  // Config table write port; a write lands at the next edge, so a tick in
  // the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FLOW_NUM; i++) cfg_tbl[i] <= '0;
    end else if (cfg_wr) begin
      cfg_tbl[cfg_idx] <= '{en: cfg_en, slot: cfg_slot};
    end
  end

  // Slot history; hist_valid suppresses the first comparison after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_hist  <= '0;
      hist_valid <= 1'b0;
    end else begin
      slot_hist  <= slot_ID;
      hist_valid <= 1'b1;
    end
  end

  // New slot detection and per-flow slot match against the current table.
  always_comb begin
    slot_tick = test_start && hist_valid && (slot_ID != slot_hist);
    for (int i = 0; i < FLOW_NUM; i++) begin
      slot_match[i] = cfg_tbl[i].en && (cfg_tbl[i].slot == slot_ID);
    end
  end

  // Pending set: a tick reloads it (overriding the ISSUE clear), disabling
  // test_start empties it, otherwise the issued flow is retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (!test_start) begin
      pending <= '0;
    end else if (slot_tick) begin
      pending <= slot_match;
    end else if (state == ISSUE) begin
      pending <= pending & ~grant;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the one-cycle select/header-request outputs.
  always_comb begin
    state_nxt    = state;
    out_selected = '0;
    out_hdr_req  = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (test_start && pending != '0) state_nxt = ARB;
      end
      ARB: begin
        state_nxt = (test_start && arb_grant != '0) ? ISSUE : IDLE;
      end
      ISSUE: begin
        out_selected = grant;
        out_hdr_req  = 1'b1;
        state_nxt    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (pkt_done) begin
          state_nxt = (pending != '0) ? ARB : IDLE;
        end else if (to_cnt == TIMEOUT_LAST) begin
          timeout   = 1'b1;
          state_nxt = (pending != '0) ? ARB : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant register, loaded from the arbiter while in ARB.
  always_ff @(posedge clk) begin
    if (rst)                grant <= '0;
    else if (state == ARB)  grant <= arb_grant;
  end

  // Done-timeout counter, cleared on the way into WAIT_DONE.
  always_ff @(posedge clk) begin
    if (rst)                     to_cnt <= '0;
    else if (state == ISSUE)     to_cnt <= '0;
    else if (state == WAIT_DONE) to_cnt <= to_cnt + 8'd1;
  end

  // Miss increment: unsent flows at a tick plus an abandoned grant.
  always_comb begin
    miss_inc = (slot_tick ? popcount_flows(pending) : 4'd0) + {3'b000, timeout};
    miss_sum = {1'b0, miss_cnt} + {{(CNT_W - 3){1'b0}}, miss_inc};
  end

  // Saturating miss counter.
  always_ff @(posedge clk) begin
    if (rst)              miss_cnt <= '0;
    else if (miss_sum[CNT_W]) miss_cnt <= '1;
    else                  miss_cnt <= miss_sum[CNT_W-1:0];
  end

  assign out_busy     = (state != IDLE);
  assign out_miss_cnt = miss_cnt;

endmodule

// File: tb/tb_tsn_slot_scheduler.sv
// Self-checking bench for tsn_slot_scheduler: expected grants are queued
// as each slot change is driven and popped as out_selected pulses appear.
module tb_tsn_slot_scheduler;

  logic        clk;
  logic        rst;
  logic        test_start;
  logic [8:0]  slot_ID;
  logic        cfg_wr;
  logic [2:0]  cfg_idx;
  logic [8:0]  cfg_slot;
  logic        cfg_en;
  logic        pkt_done;
  logic [7:0]  out_selected;
  logic        out_hdr_req;
  logic        out_busy;
  logic [31:0] out_miss_cnt;

  int          compared = 0;
  int          mismatched = 0;
  logic [7:0]  exp_q [$];

  tsn_slot_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .test_start   (test_start),
    .slot_ID      (slot_ID),
    .cfg_wr       (cfg_wr),
    .cfg_idx      (cfg_idx),
    .cfg_slot     (cfg_slot),
    .cfg_en       (cfg_en),
    .pkt_done     (pkt_done),
    .out_selected (out_selected),
    .out_hdr_req  (out_hdr_req),
    .out_busy     (out_busy),
    .out_miss_cnt (out_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Grant monitor: every select pulse must match the oldest queued grant.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_selected != 8'h00) begin
        if (exp_q.size() == 0) checkOutput("unexpected_grant", {24'h0, out_selected}, 32'h0);
        else                   checkOutput("grant_order", {24'h0, out_selected}, {24'h0, exp_q.pop_front()});
        checkOutput("hdr_req_with_sel", {31'h0, out_hdr_req}, 32'h1);
      end else if (out_hdr_req) begin
        checkOutput("hdr_req_without_sel", 32'h1, 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic [8:0] slot);
    @(negedge clk);
    slot_ID = slot;
  endtask

  task automatic cfgWrite(input logic [2:0] idx, input logic [8:0] slot, input logic en);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_idx = idx; cfg_slot = slot; cfg_en = en;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic pulseDone();
    @(negedge clk);
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
  endtask

  task automatic waitGrant(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (out_selected == 8'h00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (out_selected == 8'h00) checkOutput({tag, "_grant_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (out_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, {31'h0, out_busy}, 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1; test_start = 1'b0; slot_ID = '0; cfg_wr = 1'b0;
    cfg_idx = '0; cfg_slot = '0; cfg_en = 1'b0; pkt_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sel", {24'h0, out_selected}, 32'h0);
    checkOutput("reset_hdr", {31'h0, out_hdr_req}, 32'h0);
    checkOutput("reset_busy", {31'h0, out_busy}, 32'h0);
    checkOutput("reset_miss", out_miss_cnt, 32'h0);
    rst = 1'b0;
    test_start = 1'b1;

    // pkt_done while idle is ignored.
    pulseDone();
    checkOutput("done_idle_busy", {31'h0, out_busy}, 32'h0);

    // Flows 0 and 3 on slot 5: grant 0 at T+3, then 3.
    cfgWrite(3'd0, 9'd5, 1'b1);
    cfgWrite(3'd3, 9'd5, 1'b1);
    applyStimulus(9'd4);
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h08);
    applyStimulus(9'd5);
    repeat (2) @(negedge clk);
    checkOutput("latency_t2", {24'h0, out_selected}, 32'h0);
    @(negedge clk);
    checkOutput("latency_t3", {24'h0, out_selected}, 32'h01);
    pulseDone();
    waitGrant("second_flow");
    checkOutput("busy_in_flight", {31'h0, out_busy}, 32'h1);
    pulseDone();
    waitIdle("two_flow");
    checkOutput("two_flow_miss", out_miss_cnt, 32'h0);

    // Flows 1 and 2 on slot 7; slot moves on before flow 2 is sent.
    cfgWrite(3'd1, 9'd7, 1'b1);
    cfgWrite(3'd2, 9'd7, 1'b1);
    exp_q.push_back(8'h02);
    applyStimulus(9'd7);
    waitGrant("slot7");
    applyStimulus(9'd8);
    repeat (2) @(negedge clk);
    pulseDone();
    waitIdle("slot7");
    checkOutput("slot_change_miss", out_miss_cnt, 32'h1);

    // Flow 5 on slot 20 with pkt_done withheld: abandoned after timeout.
    cfgWrite(3'd5, 9'd20, 1'b1);
    exp_q.push_back(8'h20);
    applyStimulus(9'd20);
    waitGrant("timeout");
    n = 0;
    while (out_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", n, 32'd256);
    checkOutput("timeout_busy", {31'h0, out_busy}, 32'h0);
    checkOutput("timeout_miss", out_miss_cnt, 32'h2);

    // Flow 4 retargeted to slot 9 in the very cycle slot 9 arrives.
    cfgWrite(3'd4, 9'd30, 1'b1);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_idx = 3'd4; cfg_slot = 9'd9; cfg_en = 1'b1;
    slot_ID = 9'd9;
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("same_cycle_cfg_busy", {31'h0, out_busy}, 32'h0);
    applyStimulus(9'd10);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h10);
    applyStimulus(9'd9);
    waitGrant("slot9");
    pulseDone();
    waitIdle("slot9");

    // Flows 0..2 on slot 3, three entries, done after every grant.
    cfgWrite(3'd0, 9'd3, 1'b1);
    cfgWrite(3'd1, 9'd3, 1'b1);
    cfgWrite(3'd2, 9'd3, 1'b1);
    for (int e = 0; e < 3; e++) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h04);
      applyStimulus(9'd3);
      for (int g = 0; g < 3; g++) begin
        waitGrant("three_flow");
        pulseDone();
      end
      waitIdle("three_flow");
      applyStimulus(9'd11);
      repeat (3) @(negedge clk);
    end
    checkOutput("three_flow_miss", out_miss_cnt, 32'h2);
    checkOutput("three_flow_queue", exp_q.size(), 32'h0);

    // test_start drop: in-flight grant completes, rest dropped uncounted.
    exp_q.push_back(8'h01);
    applyStimulus(9'd3);
    waitGrant("disable");
    @(negedge clk);
    test_start = 1'b0;
    repeat (2) @(negedge clk);
    pulseDone();
    waitIdle("disable");
    repeat (10) @(negedge clk);
    checkOutput("disable_miss", out_miss_cnt, 32'h2);
    checkOutput("disable_busy", {31'h0, out_busy}, 32'h0);
    test_start = 1'b1;

    // Reset while waiting for pkt_done.
    applyStimulus(9'd13);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h01);
    applyStimulus(9'd3);
    waitGrant("reset_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_sel", {24'h0, out_selected}, 32'h0);
    checkOutput("rst_mid_busy", {31'h0, out_busy}, 32'h0);
    checkOutput("rst_mid_miss", out_miss_cnt, 32'h0);
    rst = 1'b0;
    cfgWrite(3'd0, 9'd3, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("post_rst_busy", {31'h0, out_busy}, 32'h0);
    applyStimulus(9'd14);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h01);
    applyStimulus(9'd3);
    waitGrant("post_rst");
    pulseDone();
    waitIdle("post_rst");
    checkOutput("post_rst_miss", out_miss_cnt, 32'h0);
    checkOutput("final_queue", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
